// File: rtl/pc_control_unit.sv
// Program-counter and control-transfer stage.
// Resolves jumps/branches, drives the jal/setx side-band write, counts taken transfers.
module pc_control_unit #(
  parameter int PC_W  = 12,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             is_j,
  input  logic             is_bne,
  input  logic             is_jal,
  input  logic             is_jr,
  input  logic             is_blt,
  input  logic             is_bex,
  input  logic             is_setx,
  input  logic [26:0]      target,
  input  logic [16:0]      imm,
  input  logic [31:0]      rd_val,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rstatus_val,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus1,
  output logic             redirect,
  output logic             sb_we,
  output logic [4:0]       sb_addr,
  output logic [31:0]      sb_data,
  output logic [CNT_W-1:0] taken_count
);

  logic [31:0]      imm_sx;
  logic [PC_W-1:0]  br_tgt;
  logic [PC_W-1:0]  next_pc;
  logic             bne_tk;
  logic             blt_tk;
  logic             bex_tk;
  logic             cnt_max;

  assign pc_plus1 = pc + PC_W'(1);
  assign imm_sx   = {{15{imm[16]}}, imm};
  assign br_tgt   = PC_W'(imm_sx + 32'(pc_plus1));

  assign bne_tk = is_bne && (rd_val != rs_val);
  assign blt_tk = is_blt && ($signed(rd_val) < $signed(rs_val));
  assign bex_tk = is_bex && (|rstatus_val);

  // Highest-priority taken transfer wins.
  always_comb begin
    next_pc  = pc_plus1;
    redirect = 1'b1;
    priority case (1'b1)
      is_jr:         next_pc = rd_val[PC_W-1:0];
      is_jal, is_j:  next_pc = target[PC_W-1:0];
      bex_tk:        next_pc = target[PC_W-1:0];
      bne_tk:        next_pc = br_tgt;
      blt_tk:        next_pc = br_tgt;
      default:       redirect = 1'b0;
    endcase
  end

  // Address/data are ungated; only the enable honours stall.
  always_comb begin
    sb_we   = 1'b0;
    sb_addr = 5'd0;
    sb_data = 32'd0;
    priority case (1'b1)
      is_jal: begin
        sb_we   = ~stall;
        sb_addr = 5'd31;
        sb_data = 32'(pc_plus1);
      end
      is_setx: begin
        sb_we   = ~stall;
        sb_addr = 5'd30;
        sb_data = {5'd0, target};
      end
      default: ;
    endcase
  end

  assign cnt_max = &taken_count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc          <= '0;
      taken_count <= '0;
    end else if (!stall) begin
      pc <= next_pc;
      if (redirect && !cnt_max)
        taken_count <= taken_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_control_unit.sv
// Self-checking bench for pc_control_unit.
// Reference model plus scoreboard queue of expected post-edge state.
module tb_pc_control_unit;

  logic        clock = 1'b0;
  logic        reset_n, stall;
  logic        is_j, is_bne, is_jal, is_jr;
  logic        is_blt, is_bex, is_setx;
  logic [26:0] target;
  logic [16:0] imm;
  logic [31:0] rd_val, rs_val, rstatus_val;

  logic [11:0] pc, pc_plus1;
  logic        redirect, sb_we;
  logic [4:0]  sb_addr;
  logic [31:0] sb_data;
  logic [15:0] taken_count;

  logic [11:0] s_pc, s_pc_plus1;
  logic        s_redirect, s_sb_we;
  logic [4:0]  s_sb_addr;
  logic [31:0] s_sb_data;
  logic [1:0]  s_count;

  always #5 clock = ~clock;

  pc_control_unit #(.PC_W(12), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .is_j(is_j), .is_bne(is_bne), .is_jal(is_jal),
    .is_jr(is_jr), .is_blt(is_blt), .is_bex(is_bex),
    .is_setx(is_setx), .target(target), .imm(imm),
    .rd_val(rd_val), .rs_val(rs_val),
    .rstatus_val(rstatus_val),
    .pc(pc), .pc_plus1(pc_plus1), .redirect(redirect),
    .sb_we(sb_we), .sb_addr(sb_addr), .sb_data(sb_data),
    .taken_count(taken_count)
  );

  pc_control_unit #(.PC_W(12), .CNT_W(2)) dut_sat (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .is_j(is_j), .is_bne(is_bne), .is_jal(is_jal),
    .is_jr(is_jr), .is_blt(is_blt), .is_bex(is_bex),
    .is_setx(is_setx), .target(target), .imm(imm),
    .rd_val(rd_val), .rs_val(rs_val),
    .rstatus_val(rstatus_val),
    .pc(s_pc), .pc_plus1(s_pc_plus1),
    .redirect(s_redirect), .sb_we(s_sb_we),
    .sb_addr(s_sb_addr), .sb_data(s_sb_data),
    .taken_count(s_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [11:0] pc;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t        sb_q[$];
  logic [11:0] m_pc;
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt2;

  task automatic clr();
    stall = 0; is_j = 0; is_bne = 0; is_jal = 0;
    is_jr = 0; is_blt = 0; is_bex = 0; is_setx = 0;
    target = 0; imm = 0; rd_val = 0; rs_val = 0;
    rstatus_val = 0;
  endtask

  // Check combinational outputs, push expected state, clock, compare.
  task automatic step(input string tag);
    logic [11:0] p1, npc;
    logic [31:0] bt, d;
    logic        red, we;
    logic [4:0]  a;
    exp_t        e, o;
    p1  = m_pc + 12'd1;
    bt  = {20'd0, p1} + {{15{imm[16]}}, imm};
    red = 1'b1;
    if (is_jr) npc = rd_val[11:0];
    else if (is_jal || is_j) npc = target[11:0];
    else if (is_bex && rstatus_val != 0) npc = target[11:0];
    else if (is_bne && rd_val != rs_val) npc = bt[11:0];
    else if (is_blt && $signed(rd_val) < $signed(rs_val))
      npc = bt[11:0];
    else begin
      npc = p1;
      red = 1'b0;
    end
    if (is_jal) begin
      we = 1; a = 31; d = {20'd0, p1};
    end else if (is_setx) begin
      we = 1; a = 30; d = {5'd0, target};
    end else begin
      we = 0; a = 0; d = 0;
    end
    if (stall) we = 0;
    #1;
    check({tag, ".pc_now"}, {20'd0, pc}, {20'd0, m_pc});
    check({tag, ".pc_plus1"}, {20'd0, pc_plus1}, {20'd0, p1});
    check({tag, ".redirect"}, {31'd0, redirect}, {31'd0, red});
    check({tag, ".sb_we"}, {31'd0, sb_we}, {31'd0, we});
    check({tag, ".sb_addr"}, {27'd0, sb_addr}, {27'd0, a});
    check({tag, ".sb_data"}, sb_data, d);
    if (!reset_n) begin
      e.pc = 0; e.cnt = 0; e.cnt2 = 0;
    end else if (stall) begin
      e.pc = m_pc; e.cnt = m_cnt; e.cnt2 = m_cnt2;
    end else begin
      e.pc   = npc;
      e.cnt  = (red && m_cnt != 16'hFFFF) ? m_cnt + 1 : m_cnt;
      e.cnt2 = (red && m_cnt2 != 2'd3) ? m_cnt2 + 1 : m_cnt2;
    end
    sb_q.push_back(e);
    m_pc = e.pc; m_cnt = e.cnt; m_cnt2 = e.cnt2;
    @(posedge clock);
    #1;
    o = sb_q.pop_front();
    check({tag, ".pc"}, {20'd0, pc}, {20'd0, o.pc});
    check({tag, ".cnt"}, {16'd0, taken_count}, {16'd0, o.cnt});
    check({tag, ".cnt_sat"}, {30'd0, s_count}, {30'd0, o.cnt2});
  endtask

  task automatic jump_to(input logic [11:0] t);
    clr(); is_j = 1; target = {15'd0, t};
    step("jump_to");
    clr();
  endtask

  initial begin
    clr();
    reset_n = 0;
    repeat (2) @(posedge clock);
    #1;
    check("rst.pc", {20'd0, pc}, 32'd0);
    check("rst.cnt", {16'd0, taken_count}, 32'd0);
    check("rst.pc_plus1", {20'd0, pc_plus1}, 32'd1);
    check("rst.redirect", {31'd0, redirect}, 32'd0);
    check("rst.sb_we", {31'd0, sb_we}, 32'd0);
    m_pc = 0; m_cnt = 0; m_cnt2 = 0;

    reset_n = 1;
    for (int i = 0; i < 5; i++) step("fall");
    check("fall.pc5", {20'd0, pc}, 32'd5);
    check("fall.cnt0", {16'd0, taken_count}, 32'd0);

    jump_to(10);
    is_bne = 1; rd_val = 5; rs_val = 6; imm = 17'h1FFFD;
    step("bne_tk");
    check("bne_tk.pc8", {20'd0, pc}, 32'd8);
    jump_to(10);
    is_bne = 1; rd_val = 6; rs_val = 6; imm = 17'h1FFFD;
    step("bne_nt");
    check("bne_nt.pc11", {20'd0, pc}, 32'd11);

    jump_to(20);
    is_blt = 1; rd_val = 32'hFFFFFFFF; rs_val = 1; imm = 4;
    step("blt_tk");
    check("blt_tk.pc25", {20'd0, pc}, 32'd25);
    jump_to(20);
    is_blt = 1; rd_val = 1; rs_val = 32'hFFFFFFFF; imm = 4;
    step("blt_nt");
    check("blt_nt.pc21", {20'd0, pc}, 32'd21);

    jump_to(7);
    is_jal = 1; target = 100;
    step("jal");
    check("jal.pc100", {20'd0, pc}, 32'd100);
    clr(); is_setx = 1; target = 27'h7FFFFFF;
    step("setx");
    check("setx.pc101", {20'd0, pc}, 32'd101);

    clr(); is_jr = 1; is_j = 1; rd_val = 32'h1234; target = 55;
    step("jr_prio");
    check("jr_prio.pc", {20'd0, pc}, 32'h234);

    clr(); is_bex = 1; rstatus_val = 0; target = 9;
    step("bex_nt");
    clr(); is_bex = 1; rstatus_val = 3; target = 9;
    step("bex_tk");
    check("bex_tk.pc9", {20'd0, pc}, 32'd9);

    clr(); stall = 1; is_jal = 1; target = 300;
    step("stall_jal");
    check("stall_jal.pc9", {20'd0, pc}, 32'd9);

    clr(); is_jr = 1; rd_val = 32'd4095;
    step("preload");
    clr();
    step("wrap");
    check("wrap.pc0", {20'd0, pc}, 32'd0);

    clr(); imm = 17'h1FFFF; is_bne = 1; rd_val = 1;
    step("bne_n_minus1");

    for (int i = 0; i < 5; i++) begin
      clr(); is_j = 1; target = 12'(40 + i);
      step("sat_j");
    end
    check("sat.cnt3", {30'd0, s_count}, 32'd3);

    clr(); stall = 1; is_j = 1; target = 77; reset_n = 0;
    step("rst_stall");
    check("rst_stall.pc0", {20'd0, pc}, 32'd0);
    check("rst_stall.cnt0", {16'd0, taken_count}, 32'd0);
    reset_n = 1;
    step("stall_after_rst");
    check("stall_after_rst.pc0", {20'd0, pc}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
